// File: rtl/pic_pkg.sv
// Shared types, constants and helpers for the 8259 priority resolver.
// Rotation is enabled by defining PIC_PRIORITY_ROTATE_EN.
package pic_pkg;

  localparam int IR_W = 8;
  localparam logic [2:0] LOWEST_RESET = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACK1
  } state_t;

  // 0 = highest priority, 7 = lowest, relative to the rotation pointer
  function automatic logic [2:0] pic_rank(
    input logic [2:0] lvl,
    input logic [2:0] lowest
  );
    return lvl - lowest - 3'd1;
  endfunction

  function automatic logic [IR_W-1:0] pic_bit(
    input logic [2:0] lvl
  );
    return IR_W'(1) << lvl;
  endfunction

endpackage

// File: rtl/pic_priority_encoder.sv
// Rotating find-first: returns the set bit of vec that sits
// closest after lowest, walking upward modulo 8.
module pic_priority_encoder
  import pic_pkg::*;
(
  input  logic [IR_W-1:0] vec,
  input  logic [2:0]      lowest,
  output logic            valid,
  output logic [2:0]      level
);

  logic [2:0] idx;

  // walk from lowest to highest priority so the best hit lands last
  always_comb begin
    level = '0;
    idx   = '0;
    for (int i = IR_W - 1; i >= 0; i--) begin
      idx = lowest + 3'(i) + 3'd1;
      if (vec[idx]) level = idx;
    end
  end

  assign valid = |vec;

endmodule

// File: rtl/pic_priority_resolver.sv
// 8259 IRR/ISR bookkeeping, nested priority arbitration and INTA_ tracking.
// Define PIC_PRIORITY_ROTATE_EN for a rotating LOWEST pointer.
module pic_priority_resolver
  import pic_pkg::*;
#(
  parameter logic [2:0] SPURIOUS_IR = 3'd7
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [IR_W-1:0] IR_IN,
  input  logic            LEVEL,
  input  logic [IR_W-1:0] interrupt_mask,
  input  logic            INTA_,
  input  logic            AEOI,
  input  logic            R,
  input  logic            EOI_STB,
  input  logic            EOI_SL,
  input  logic [2:0]      EOI_LEVEL,
  input  logic            RIRR,
  input  logic            RISR,
  output logic            INTERNAL_INT,
  output logic [2:0]      IR_NUM,
  output logic [IR_W-1:0] IRR,
  output logic [IR_W-1:0] ISR,
  output logic [IR_W-1:0] READ_REG
);

  state_t state;
  state_t state_nx;

  logic [IR_W-1:0] ir_prev;
  logic [IR_W-1:0] irr;
  logic [IR_W-1:0] isr;
  logic [IR_W-1:0] read_q;
  logic [2:0]      lowest;
  logic [2:0]      ir_num;
  logic            inta_prev;
  logic            ack_real;

  logic [IR_W-1:0] active;
  logic [IR_W-1:0] rise;
  logic [IR_W-1:0] fall;
  logic [IR_W-1:0] ack_set;
  logic [IR_W-1:0] isr_clr;
  logic            cand_v;
  logic [2:0]      cand_lvl;
  logic            isr_v;
  logic [2:0]      isr_lvl;
  logic            cand_ok;
  logic            inta_fall;
  logic            ack1;
  logic            ack2;
  logic            eoi_hit;
  logic [2:0]      eoi_lvl;
  logic            aeoi_hit;
  logic            unused_rirr;

  assign active = irr & ~interrupt_mask;

  pic_priority_encoder u_cand (
    .vec    (active),
    .lowest (lowest),
    .valid  (cand_v),
    .level  (cand_lvl)
  );

  pic_priority_encoder u_isr (
    .vec    (isr),
    .lowest (lowest),
    .valid  (isr_v),
    .level  (isr_lvl)
  );

  // equal or lower priority than anything in service must wait
  assign cand_ok = cand_v &
    (!isr_v ||
     (pic_rank(cand_lvl, lowest) < pic_rank(isr_lvl, lowest)));

  assign inta_fall = inta_prev & ~INTA_;
  assign ack1      = (state == REQ) & inta_fall;
  assign ack2      = (state == ACK1) & inta_fall;
  assign ack_set   = (ack1 && cand_ok) ? pic_bit(cand_lvl) : '0;

  assign eoi_hit   = EOI_STB & (EOI_SL | isr_v);
  assign eoi_lvl   = EOI_SL ? EOI_LEVEL : isr_lvl;
  assign aeoi_hit  = ack2 & AEOI & ack_real;
  assign isr_clr   = (eoi_hit ? pic_bit(eoi_lvl) : '0) |
                     (aeoi_hit ? pic_bit(ir_num) : '0);

  assign rise = IR_IN & ~ir_prev;
  assign fall = ~IR_IN & ir_prev;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (cand_ok) state_nx = REQ;
      REQ: begin
        if (inta_fall)     state_nx = ACK1;
        else if (!cand_ok) state_nx = IDLE;
      end
      ACK1: if (inta_fall) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    INTERNAL_INT = (state == REQ);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ir_prev   <= '0;
      irr       <= '0;
      isr       <= '0;
      read_q    <= '0;
      ir_num    <= '0;
      inta_prev <= 1'b1;
      ack_real  <= 1'b0;
    end else begin
      ir_prev   <= IR_IN;
      inta_prev <= INTA_;
      if (LEVEL) irr <= IR_IN & ~ack_set;
      else       irr <= (irr & ~fall & ~ack_set) | rise;
      isr <= (isr & ~isr_clr) | ack_set;
      if (ack1) begin
        ir_num   <= cand_ok ? cand_lvl : SPURIOUS_IR;
        ack_real <= cand_ok;
      end else if (state != ACK1 && cand_ok) begin
        ir_num <= cand_lvl;
      end
      read_q <= RISR ? isr : irr;
    end
  end

`ifdef PIC_PRIORITY_ROTATE_EN
  always_ff @(posedge CLK) begin
    if (RST)                  lowest <= LOWEST_RESET;
    else if (eoi_hit && R)    lowest <= eoi_lvl;
    else if (aeoi_hit && R)   lowest <= ir_num;
  end
`else
  logic unused_r;
  assign lowest   = LOWEST_RESET;
  assign unused_r = R;
`endif

  // IRR is the default read source, so RIRR carries no extra decode
  assign unused_rirr = RIRR;

  assign IR_NUM   = ir_num;
  assign IRR      = irr;
  assign ISR      = isr;
  assign READ_REG = read_q;

endmodule
